fib_seq_gen: RTL

Fibonacci term generator in the user project area that drives the 16-bit user output field on `mprj_io[23:8]`, which the chip-level count test monitors for 5, 55 and 144. It steps through F0, F1, F2, … and holds each term for a programmable number of clocks. It handles pause, restart and 16-bit overflow deterministically, and exposes a term strobe and index for the logic analyzer.

---
 rtl/fib_pkg.sv | 34 +++
 rtl/fib_prescaler.sv | 47 ++++
 rtl/fib_seq_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term generator.
package fib_pkg;

  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fib_state_e;

  // Largest n such that Fn still fits in an unsigned word of the given width.
  function automatic int unsigned last_valid_idx(input int unsigned width);
    longint unsigned lim;
    longint unsigned fa;
    longint unsigned fb;
    longint unsigned t;
    int unsigned     n;
    lim = 64'd1 << width;
    fa  = 64'd0;
    fb  = 64'd1;
    n   = 0;
    for (int i = 0; i < 64; i++) begin
      if (fb < lim) begin
        t  = fa + fb;
        fa = fb;
        fb = t;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fib_prescaler.sv
// Term hold-period counter: latches div at each term boundary and flags the last clock of a term.
module fib_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             at_end;

  assign at_end = (cnt_q == div_q);
  assign tick   = run && at_end;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (restart) begin
      cnt_d = '0;
      div_d = div;
    end else if (run) begin
      if (at_end) begin
        // Boundary: the new hold period governs the term that starts now.
        cnt_d = '0;
        div_d = div;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator driving the user IO field; each term is held div+1 clocks.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV_W = 16,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             wb_clk_i,
  input  logic             resetb,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             term_stb,
  output logic [IDX_W-1:0] idx,
  output logic             done
);

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             b_ok_q, b_ok_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] oeb_q, oeb_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             run;
  logic             restart;
  logic             tick;

  // One extra bit so an overflowing term is detected instead of wrapping.
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign run = (state_q == StRun) && en && !clear;

  fib_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (wb_clk_i),
    .rst_n  (resetb),
    .run    (run),
    .restart(restart),
    .div    (div),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    b_ok_d  = b_ok_q;
    idx_d   = idx_q;
    oeb_d   = oeb_q;
    stb_d   = 1'b0;
    done_d  = done_q;
    restart = 1'b0;

    if (clear) begin
      state_d = StIdle;
      a_d     = '0;
      b_d     = WIDTH'(1);
      b_ok_d  = 1'b1;
      idx_d   = '0;
      oeb_d   = '1;
      done_d  = 1'b0;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            // a/b/idx already hold F0/F1/0 here, so presenting F0 is just the strobe.
            state_d = StRun;
            oeb_d   = '0;
            stb_d   = 1'b1;
            restart = 1'b1;
          end
        end
        StRun: begin
          if (tick) begin
            if (b_ok_q) begin
              a_d    = b_q;
              b_d    = sum[WIDTH-1:0];
              b_ok_d = !sum[WIDTH];
              idx_d  = idx_q + IDX_W'(1);
              stb_d  = 1'b1;
            end else if (WRAP) begin
              a_d    = '0;
              b_d    = WIDTH'(1);
              b_ok_d = 1'b1;
              idx_d  = '0;
              stb_d  = 1'b1;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      b_ok_q  <= 1'b1;
      idx_q   <= '0;
      oeb_q   <= '1;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      b_ok_q  <= b_ok_d;
      idx_q   <= idx_d;
      oeb_q   <= oeb_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
    end
  end

  assign io_out   = a_q;
  assign io_oeb   = oeb_q;
  assign term_stb = stb_q;
  assign idx      = idx_q;
  assign done     = done_q;

endmodule
